modulation_sampler: RTL
=======================

Name: modulation_sampler

Overview:
- Sequences the read port of the modulation BRAM.
- Steps a sample index through 0..CYCLE at a rate set by FREQ_DIV and presents the index on the BRAM read address.
- Realigns the BRAM read data with the index that produced it and emits one M_VALID pulse per sample.
- Sits between the controller configuration registers and the modulation memory. Its outputs feed the downstream modulation multiplier.

Parameters:
- ADDR_WIDTH, 16: width of BRAM read address and sample index.
- DATA_WIDTH, 8: width of modulation sample.
- DIV_WIDTH, 32: width of frequency-division value and its counter.
- BRAM_LATENCY, 2: cycles from ADDR change to matching data on M_IN. Legal range 1..4.

Ports:
- CLK  in  1  system clock; all logic is in this single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse; begins sampling from index 0.
- STOP  in  1  one-cycle pulse; ends sampling.
- CYCLE  in  ADDR_WIDTH  last valid index (sequence length minus 1).
- FREQ_DIV  in  DIV_WIDTH  CLK cycles per sample; 0 is treated as 1.
- ADDR  out  ADDR_WIDTH  registered BRAM read address.
- M_IN  in  DATA_WIDTH  BRAM read data.
- M  out  DATA_WIDTH  registered sample.
- IDX  out  ADDR_WIDTH  index that produced M.
- M_VALID  out  1  one-cycle pulse when M/IDX update.
- WRAP  out  1  pulse, coincident with M_VALID, when IDX==CYCLE.
- BUSY  out  1  high in RUN and DRAIN.

Behaviour:
- Reset (async, any time, including mid-run):
  - state=IDLE.
  - ADDR, M, IDX, div_cnt, idx all =0.
  - M_VALID, WRAP, BUSY =0.
  - Pipeline valid bits cleared.
  - No pulse may appear on the first edge after RST deasserts.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - ADDR holds its last value; no reads are tagged valid.
  - START (with STOP low) at edge E0: latch CYCLE->cyc_r and max(FREQ_DIV,1)->div_r.
  - Also at E0: set ADDR=0, idx=0, div_cnt=0, issue tag {valid=1, idx=0}, go to RUN.
- RUN:
  - Each edge: if div_cnt==div_r-1, then div_cnt=0, idx=(idx==cyc_r)?0:idx+1, ADDR=new idx, issue tag. Otherwise div_cnt+=1.
  - First read is issued at E0; subsequent reads every div_r cycles (E0+div_r, E0+2*div_r, ...).
  - START is ignored in RUN. Changes to CYCLE or FREQ_DIV are ignored until the next START.
  - STOP at any edge: go to DRAIN; no new tag is issued on that edge.
- DRAIN:
  - Stay BRAM_LATENCY+1 cycles so that every issued tag completes.
  - Then go to IDLE; BUSY falls on that edge.
  - START in DRAIN is ignored.
- Simultaneous START and STOP: STOP wins. From IDLE, remain in IDLE.
- Tag pipeline:
  - Shift register of depth BRAM_LATENCY carrying {valid, idx}.
  - At edge E+BRAM_LATENCY+1 after a tag issued at edge E: M=M_IN, IDX=tag idx, M_VALID=1, WRAP=(tag idx==cyc_r).
  - Result: START-to-first-M_VALID latency is BRAM_LATENCY+1 cycles (3 by default).
- div_r==1: a new index every cycle; M_VALID stays high continuously once the pipeline is full.
- cyc_r==0: index stays 0; WRAP accompanies every M_VALID.
- Arithmetic:
  - Index compare and increment are unsigned in ADDR_WIDTH; no overflow beyond cyc_r.
  - div_cnt is unsigned DIV_WIDTH; compare uses div_r-1 computed at latch time.

Decomposition:
- Shared package mod_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - the tag struct {valid, idx};
  - the BRAM_LATENCY default constant.
- Sub-module mod_tag_pipe: parameterised delay line for tags, with async reset clearing all valid bits.
- The counter/FSM stays in the top module.

Test Plan:
- Reset then START with CYCLE=3, FREQ_DIV=4 -> ADDR sequence 0,1,2,3,0 changing every 4 cycles. First M_VALID 3 cycles after START; IDX 0,1,2,3,0; WRAP with IDX=3.
- FREQ_DIV=0 and FREQ_DIV=1, CYCLE=7 -> identical output: M_VALID continuous after 3 cycles, M matches BRAM model contents for ADDR 0..7 repeating.
- STOP issued 1 cycle after a read -> that read's M_VALID still appears, no further pulses. BUSY falls 3 cycles after STOP. START during DRAIN has no effect.
- START and STOP in the same cycle from IDLE -> stays IDLE: BUSY=0, no M_VALID. CYCLE changed mid-run from 3 to 9 -> sequence still wraps at 3.
- RST asserted mid-RUN, between a read issue and its data -> outputs 0 immediately. The pending M_VALID never appears; a later START restarts at IDX=0.
- CYCLE=0, FREQ_DIV=2 -> ADDR constant 0; M_VALID every 2 cycles, each with WRAP=1.

Source files
------------

// File: rtl/mod_pkg.sv
// Shared types for the modulation sampler: FSM states, the read tag carried
// alongside each BRAM read, and the default BRAM read latency.
package mod_pkg;

  localparam int IDX_W            = 16;
  localparam int BRAM_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/mod_tag_pipe.sv
// Delay line for read tags so each tag lines up with the BRAM data it requested.
module mod_tag_pipe
  import mod_pkg::*;
#(
  parameter int DEPTH = BRAM_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t d,
  output tag_t q
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/modulation_sampler.sv
// Steps a sample index through the modulation BRAM at a divided rate and
// realigns the returned data with its index. ADDR_WIDTH must equal IDX_W.
module modulation_sampler
  import mod_pkg::*;
#(
  parameter int ADDR_WIDTH   = IDX_W,
  parameter int DATA_WIDTH   = 8,
  parameter int DIV_WIDTH    = 32,
  parameter int BRAM_LATENCY = BRAM_LATENCY_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [ADDR_WIDTH-1:0] CYCLE,
  input  logic [DIV_WIDTH-1:0]  FREQ_DIV,
  output logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] M_IN,
  output logic [DATA_WIDTH-1:0] M,
  output logic [ADDR_WIDTH-1:0] IDX,
  output logic                  M_VALID,
  output logic                  WRAP,
  output logic                  BUSY
);

  localparam logic [2:0] DRAIN_LAST = 3'(BRAM_LATENCY);

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  cyc_r;
  logic [DIV_WIDTH-1:0]   divm1_r;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [ADDR_WIDTH-1:0]  idx_next;
  logic [2:0]             drain_cnt;
  tag_t                   tag_p0;
  tag_t                   tag_pl;

  always_comb begin
    idx_next = (idx == cyc_r) ? '0 : idx + ADDR_WIDTH'(1);
  end

  // Stage p0: sequencer; ADDR and its issue tag are registered together
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cyc_r     <= '0;
      divm1_r   <= '0;
      div_cnt   <= '0;
      idx       <= '0;
      ADDR      <= '0;
      drain_cnt <= '0;
      BUSY      <= 1'b0;
      tag_p0    <= '0;
    end else begin
      tag_p0.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (START && !STOP) begin
            cyc_r   <= CYCLE;
            divm1_r <= (FREQ_DIV == '0) ? '0 : FREQ_DIV - DIV_WIDTH'(1);
            div_cnt <= '0;
            idx     <= '0;
            ADDR    <= '0;
            tag_p0  <= '{valid: 1'b1, idx: '0};
            BUSY    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (STOP) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end else if (div_cnt == divm1_r) begin
            div_cnt <= '0;
            idx     <= idx_next;
            ADDR    <= idx_next;
            tag_p0  <= '{valid: 1'b1, idx: IDX_W'(idx_next)};
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        DRAIN: begin
          // Hold long enough for the last issued tag to reach the output
          if (drain_cnt == DRAIN_LAST) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mod_tag_pipe #(
    .DEPTH (BRAM_LATENCY)
  ) u_tag_pipe (
    .clk (CLK),
    .rst (RST),
    .d   (tag_p0),
    .q   (tag_pl)
  );

  // Output stage: capture BRAM data alongside the tag that requested it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      M       <= '0;
      IDX     <= '0;
      M_VALID <= 1'b0;
      WRAP    <= 1'b0;
    end else begin
      M_VALID <= tag_pl.valid;
      WRAP    <= tag_pl.valid && (ADDR_WIDTH'(tag_pl.idx) == cyc_r);
      if (tag_pl.valid) begin
        M   <= M_IN;
        IDX <= ADDR_WIDTH'(tag_pl.idx);
      end
    end
  end

endmodule
